// File: rtl/p4_ue_bridge_pkg.sv
// Shared types for the VNP4 user-extern to AXI-Stream bridge.
// Order tags, response FSM states and counter width.
package p4_ue_bridge_pkg;

    typedef enum logic {
        UE_TAG_NORMAL,
        UE_TAG_DROPPED
    } ue_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ENG,
        DROP
    } resp_state_t;

    localparam int UE_COUNTER_BITS = 32;

endpackage

// File: rtl/axis_int.sv
// Minimal AXI-Stream bundle with master/slave views.
// Single-clock use: the owning block's clock times every beat.
interface AXIS_int #(
    parameter int DATA_BYTES = 1
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport Master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport Slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/p4_ue_bridge_fifo.sv
// First-word-fall-through FIFO with registered occupancy.
// Full/empty come from the registered level, so a pop never frees room for a same-cycle push.
module p4_ue_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/p4_user_extern_axis_bridge.sv
// VNP4 user-extern to AXI-Stream engine bridge with in-order responses and drop-on-overflow.
// Optional counters: define P4_UE_BRIDGE_COUNTERS_EN.
import p4_ue_bridge_pkg::*;

module p4_user_extern_axis_bridge #(
    parameter int UE_IN_DATA_BITS  = 160,
    parameter int UE_OUT_DATA_BITS = 16,
    parameter int REQ_FIFO_DEPTH   = 16,
    parameter int MAX_OUTSTANDING  = 32,
    parameter logic [UE_OUT_DATA_BITS-1:0] DROP_RESP_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               aresetn,
    input  logic [UE_IN_DATA_BITS-1:0]         ue_req_data,
    input  logic                               ue_req_valid,
    output logic [UE_OUT_DATA_BITS-1:0]        ue_resp_data,
    output logic                               ue_resp_valid,
    AXIS_int.Master                            axis_req,
    AXIS_int.Slave                             axis_resp,
    output logic                               overflow,
    output logic                               order_lost,
    input  logic                               clear_sticky,
    output logic [$clog2(REQ_FIFO_DEPTH):0]    req_level,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic [UE_COUNTER_BITS-1:0]         req_count,
    output logic [UE_COUNTER_BITS-1:0]         drop_count,
    output logic [UE_COUNTER_BITS-1:0]         resp_count
);
    logic                       req_full;
    logic                       req_empty;
    logic                       req_push;
    logic                       req_pop;
    logic [UE_IN_DATA_BITS-1:0] req_head;

    logic        tag_full;
    logic        tag_empty;
    logic        tag_push;
    logic        tag_pop;
    logic [0:0]  tag_head_raw;
    ue_tag_t     tag_head;
    ue_tag_t     tag_in;

    logic        drop_set;
    logic        lost_set;
    logic        resp_hs;
    resp_state_t state;
    logic        unused_resp_bits;

    assign tag_push = ue_req_valid && !tag_full;
    assign req_push = tag_push && !req_full;
    assign tag_in   = req_full ? UE_TAG_DROPPED : UE_TAG_NORMAL;
    assign drop_set = tag_push && req_full;
    assign lost_set = ue_req_valid && tag_full;

    p4_ue_bridge_fifo #(
        .WIDTH (UE_IN_DATA_BITS),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (aresetn),
        .push      (req_push),
        .push_data (ue_req_data),
        .pop       (req_pop),
        .pop_data  (req_head),
        .empty     (req_empty),
        .full      (req_full),
        .level     (req_level)
    );

    p4_ue_bridge_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (aresetn),
        .push      (tag_push),
        .push_data (tag_in),
        .pop       (tag_pop),
        .pop_data  (tag_head_raw),
        .empty     (tag_empty),
        .full      (tag_full),
        .level     (outstanding)
    );

    always_comb begin
        axis_req.tdata = '0;
        axis_req.tdata[UE_IN_DATA_BITS-1:0] = req_head;
    end

    assign axis_req.tkeep  = '1;
    assign axis_req.tlast  = 1'b1;
    assign axis_req.tvalid = !req_empty;
    assign req_pop         = axis_req.tvalid && axis_req.tready;

    // The tag FIFO head is the FSM state, so a new head is served the very next cycle.
    assign tag_head = ue_tag_t'(tag_head_raw);

    always_comb begin
        if (tag_empty) begin
            state = IDLE;
        end else if (tag_head == UE_TAG_DROPPED) begin
            state = DROP;
        end else begin
            state = WAIT_ENG;
        end
    end

    assign axis_resp.tready = state == WAIT_ENG;
    assign resp_hs          = (state == WAIT_ENG) && axis_resp.tvalid;
    assign tag_pop          = resp_hs || (state == DROP);

    // tlast, tkeep and bits above the response field carry no meaning here.
    assign unused_resp_bits = &{1'b0, axis_resp.tdata, axis_resp.tkeep, axis_resp.tlast};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ue_resp_valid <= 1'b0;
            ue_resp_data  <= '0;
        end else begin
            ue_resp_valid <= tag_pop;
            if (state == DROP) begin
                ue_resp_data <= DROP_RESP_VALUE;
            end else if (resp_hs) begin
                ue_resp_data <= axis_resp.tdata[UE_OUT_DATA_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow   <= 1'b0;
            order_lost <= 1'b0;
        end else begin
            if (drop_set) begin
                overflow <= 1'b1;
            end else if (clear_sticky) begin
                overflow <= 1'b0;
            end
            if (lost_set) begin
                order_lost <= 1'b1;
            end else if (clear_sticky) begin
                order_lost <= 1'b0;
            end
        end
    end

`ifdef P4_UE_BRIDGE_COUNTERS_EN
    logic [UE_COUNTER_BITS-1:0] req_cnt;
    logic [UE_COUNTER_BITS-1:0] drop_cnt;
    logic [UE_COUNTER_BITS-1:0] resp_cnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            req_cnt  <= '0;
            drop_cnt <= '0;
            resp_cnt <= '0;
        end else begin
            if (ue_req_valid && req_cnt != '1) begin
                req_cnt <= req_cnt + UE_COUNTER_BITS'(1);
            end
            if ((drop_set || lost_set) && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + UE_COUNTER_BITS'(1);
            end
            if (ue_resp_valid && resp_cnt != '1) begin
                resp_cnt <= resp_cnt + UE_COUNTER_BITS'(1);
            end
        end
    end

    assign req_count  = req_cnt;
    assign drop_count = drop_cnt;
    assign resp_count = resp_cnt;
`else
    assign req_count  = '0;
    assign drop_count = '0;
    assign resp_count = '0;
`endif

endmodule

// File: tb/tb_p4_user_extern_axis_bridge.sv
// Randomised bench for p4_user_extern_axis_bridge against a queue-based reference model.
// Counter expectations follow P4_UE_BRIDGE_COUNTERS_EN.
module tb_p4_user_extern_axis_bridge;
    localparam int IN_W  = 160;
    localparam int OUT_W = 16;
    localparam int DEPTH = 16;
    localparam int MAXO  = 32;
    localparam logic [OUT_W-1:0] DROPV = 16'hDEAD;
`ifdef P4_UE_BRIDGE_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [IN_W-1:0]   ue_req_data = '0;
    logic              ue_req_valid = 1'b0;
    logic [OUT_W-1:0]  ue_resp_data;
    logic              ue_resp_valid;
    logic              overflow;
    logic              order_lost;
    logic              clear_sticky = 1'b0;
    logic [4:0]        req_level;
    logic [5:0]        outstanding;
    logic [31:0]       req_count;
    logic [31:0]       drop_count;
    logic [31:0]       resp_count;

    AXIS_int #(.DATA_BYTES(20)) axis_req_if ();
    AXIS_int #(.DATA_BYTES(2))  axis_resp_if ();

    p4_user_extern_axis_bridge #(
        .UE_IN_DATA_BITS  (IN_W),
        .UE_OUT_DATA_BITS (OUT_W),
        .REQ_FIFO_DEPTH   (DEPTH),
        .MAX_OUTSTANDING  (MAXO),
        .DROP_RESP_VALUE  (DROPV)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .ue_req_data   (ue_req_data),
        .ue_req_valid  (ue_req_valid),
        .ue_resp_data  (ue_resp_data),
        .ue_resp_valid (ue_resp_valid),
        .axis_req      (axis_req_if),
        .axis_resp     (axis_resp_if),
        .overflow      (overflow),
        .order_lost    (order_lost),
        .clear_sticky  (clear_sticky),
        .req_level     (req_level),
        .outstanding   (outstanding),
        .req_count     (req_count),
        .drop_count    (drop_count),
        .resp_count    (resp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               drop;
        logic [OUT_W-1:0] val;
    } mtag_t;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [IN_W-1:0]  m_req[$];
    mtag_t            m_tag[$];
    bit               m_ov, m_ol;
    logic [31:0]      m_reqc, m_dropc, m_respc;
    int               m_lost;
    bit               exp_v;
    logic [OUT_W-1:0] exp_d;

    logic [OUT_W-1:0] e_q[$];
    int               e_t[$];
    bit               e_v;

    int tready_pct = 100;
    int tvalid_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    bit clr = 1'b0;

    logic [OUT_W-1:0] log_d[$];
    int               log_c[$];

    function automatic logic [OUT_W-1:0] eng_f(input logic [IN_W-1:0] p);
        return p[15:0] ^ p[159:144] ^ 16'h3C3C;
    endfunction

    function automatic logic [IN_W-1:0] rnd_payload();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [IN_W-1:0] act,
                       input logic [IN_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_req.delete();
        m_tag.delete();
        m_ov = 0;
        m_ol = 0;
        m_reqc = '0;
        m_dropc = '0;
        m_respc = '0;
        m_lost = 0;
        exp_v = 0;
        exp_d = '0;
        e_q.delete();
        e_t.delete();
        e_v = 0;
        log_d.delete();
        log_c.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_resp_valid", ue_resp_valid, 0);
        chk("rst_resp_data", ue_resp_data, 0);
        chk("rst_req_tvalid", axis_req_if.tvalid, 0);
        chk("rst_resp_tready", axis_resp_if.tready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_order_lost", order_lost, 0);
        chk("rst_req_level", req_level, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_req_count", req_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_resp_count", resp_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        ue_req_valid = 1'b0;
        clear_sticky = 1'b0;
        clr = 1'b0;
        axis_req_if.tready = 1'b0;
        axis_resp_if.tvalid = 1'b0;
        #1;
        chk_reset_vals();
        model_reset();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model over the next edge.
    task automatic step(input bit rv, input logic [IN_W-1:0] rd);
        int rs, ts;
        bit rpop, tpop, hs;
        logic [OUT_W-1:0] hd;
        @(negedge clk);
        cyc++;
        chk("req_tvalid", axis_req_if.tvalid, m_req.size() != 0);
        if (m_req.size() != 0) begin
            chk("req_tdata", axis_req_if.tdata, m_req[0]);
            chk("req_tkeep", axis_req_if.tkeep, 20'hFFFFF);
            chk("req_tlast", axis_req_if.tlast, 1);
        end
        chk("resp_tready", axis_resp_if.tready, m_tag.size() != 0 && !m_tag[0].drop);
        chk("ue_resp_valid", ue_resp_valid, exp_v);
        if (exp_v) begin
            chk("ue_resp_data", ue_resp_data, exp_d);
            log_d.push_back(ue_resp_data);
            log_c.push_back(cyc);
        end
        chk("req_level", req_level, m_req.size());
        chk("outstanding", outstanding, m_tag.size());
        chk("overflow", overflow, m_ov);
        chk("order_lost", order_lost, m_ol);
        chk("req_count", req_count, CNT_EN ? m_reqc : 32'h0);
        chk("drop_count", drop_count, CNT_EN ? m_dropc : 32'h0);
        chk("resp_count", resp_count, CNT_EN ? m_respc : 32'h0);

        ue_req_valid = rv;
        ue_req_data = rd;
        clear_sticky = clr;
        axis_req_if.tready = ($urandom_range(0, 99) < tready_pct);
        if (!e_v && e_q.size() != 0 && e_t[0] <= cyc && $urandom_range(0, 99) < tvalid_pct)
            e_v = 1;
        axis_resp_if.tvalid = e_v;
        axis_resp_if.tdata = e_v ? e_q[0] : 16'($urandom);
        axis_resp_if.tkeep = 2'b11;
        axis_resp_if.tlast = 1'($urandom);

        rs = m_req.size();
        ts = m_tag.size();
        rpop = rs != 0 && axis_req_if.tready;
        tpop = ts != 0 && (m_tag[0].drop || e_v);
        hs = tpop && !m_tag[0].drop;
        if (exp_v && m_respc != '1) m_respc++;
        hd = '0;
        if (tpop) begin
            hd = m_tag[0].val;
            void'(m_tag.pop_front());
        end
        exp_v = tpop;
        if (tpop) exp_d = hd;
        if (rpop) begin
            e_q.push_back(eng_f(axis_req_if.tdata));
            e_t.push_back(cyc + $urandom_range(lat_min, lat_max));
            void'(m_req.pop_front());
        end
        if (hs) begin
            void'(e_q.pop_front());
            void'(e_t.pop_front());
            e_v = 0;
        end
        if (clr) begin
            m_ov = 0;
            m_ol = 0;
        end
        if (rv) begin
            if (m_reqc != '1) m_reqc++;
            if (ts == MAXO) begin
                m_ol = 1;
                m_lost++;
                if (m_dropc != '1) m_dropc++;
            end else if (rs == DEPTH) begin
                m_tag.push_back('{drop: 1'b1, val: DROPV});
                m_ov = 1;
                if (m_dropc != '1) m_dropc++;
            end else begin
                m_req.push_back(rd);
                m_tag.push_back('{drop: 1'b0, val: eng_f(rd)});
            end
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((m_tag.size() != 0 || m_req.size() != 0 || exp_v || e_q.size() != 0) && n < maxc) begin
            step(0, '0);
            n++;
        end
        chk("drain_within_budget", n < maxc, 1);
        step(0, '0);
    endtask

    initial begin
        int c0;
        int issued;
        bit r;
        model_reset();
        do_reset();

        // single request, engine latency 3
        lat_min = 3;
        lat_max = 3;
        tready_pct = 100;
        tvalid_pct = 100;
        step(1, 160'hA5);
        c0 = cyc;
        drain(50);
        chk("t1_resp_num", log_d.size(), 1);
        chk("t1_resp_data", log_d[0], 16'h3C99);
        chk("t1_latency", log_c[0] - c0, 5);
        chk("t1_resp_count", resp_count, CNT_EN ? 32'd1 : 32'd0);

        // 20 back-to-back with engine stalled
        do_reset();
        lat_min = 1;
        lat_max = 2;
        tready_pct = 0;
        for (int i = 0; i < 20; i++) step(1, IN_W'(i + 1));
        step(0, '0);
        chk("t2_req_level", req_level, 16);
        chk("t2_outstanding", outstanding, 20);
        chk("t2_overflow", overflow, 1);
        tready_pct = 100;
        drain(200);
        chk("t2_resp_num", log_d.size(), 20);
        chk("t2_first", log_d[0], 16'h3C3D);
        chk("t2_sixteenth", log_d[15], 16'h3C2C);
        for (int i = 16; i < 20; i++) chk("t2_drop_resp", log_d[i], 16'hDEAD);
        chk("t2_drop_count", drop_count, CNT_EN ? 32'd4 : 32'd0);
        chk("t2_overflow_sticky", overflow, 1);
        clr = 1'b1;
        step(0, '0);
        clr = 1'b0;
        step(0, '0);
        chk("t2_overflow_cleared", overflow, 0);

        // tag FIFO exhaustion
        do_reset();
        tready_pct = 0;
        for (int i = 0; i < 33; i++) step(1, rnd_payload());
        step(0, '0);
        chk("t3_order_lost", order_lost, 1);
        chk("t3_outstanding", outstanding, 32);
        chk("t3_req_count", req_count, CNT_EN ? 32'd33 : 32'd0);
        clr = 1'b1;
        step(0, '0);
        clr = 1'b0;
        step(0, '0);
        chk("t3_order_lost_cleared", order_lost, 0);
        tready_pct = 100;
        drain(300);
        chk("t3_resp_num", log_d.size(), 32);
        chk("t3_last_drop", log_d[31], 16'hDEAD);
        chk("t3_drop_count", drop_count, CNT_EN ? 32'd17 : 32'd0);

        // random traffic with gaps on both engine channels
        do_reset();
        lat_min = 1;
        lat_max = 5;
        tvalid_pct = 70;
        issued = 0;
        while (issued < 1000) begin
            if (cyc % 64 == 0) tready_pct = $urandom_range(20, 100);
            r = $urandom_range(0, 1) == 1;
            step(r, rnd_payload());
            if (r) issued++;
        end
        tready_pct = 100;
        drain(3000);
        chk("t4_resp_num", log_d.size(), 1000 - m_lost);

        // reset with 8 requests outstanding
        do_reset();
        tready_pct = 100;
        tvalid_pct = 0;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 8; i++) step(1, rnd_payload());
        step(0, '0);
        chk("t5_outstanding", outstanding, 8);
        do_reset();
        tvalid_pct = 100;
        step(1, 160'hA5);
        drain(50);
        chk("t5_resp_num", log_d.size(), 1);
        chk("t5_resp_data", log_d[0], 16'h3C99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
